// File: rtl/pulse_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sched_pkg
// Brief    : Shared state encoding and LFSR constants for the pulse scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage
`default_nettype wire

// File: rtl/pulse_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : pulse_lfsr
// Brief    : Free-running Galois LFSR with masked low-bits output.
//            Optional seed loading when PULSE_SCHED_SEED_LOAD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_lfsr
   import pulse_sched_pkg::*;
#(
   parameter int LFSR_W = 16,
   parameter int GAP_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
`ifdef PULSE_SCHED_SEED_LOAD_EN
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
`endif
   input  logic [GAP_W-1:0]  mask,
   output logic [GAP_W-1:0]  masked
);

   localparam logic [LFSR_W-1:0] c_seed = LFSR_W'(LFSR_SEED);
   localparam logic [LFSR_W-1:0] c_taps = LFSR_W'(LFSR_TAPS);

   logic [LFSR_W-1:0] r_lfsr;
   logic [LFSR_W-1:0] w_next;

   always_comb begin
      w_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_taps : '0);
`ifdef PULSE_SCHED_SEED_LOAD_EN
      // a zero seed would lock the register, so fall back to the reset seed
      if (seed_load) begin
         w_next = (seed_in == '0) ? c_seed : seed_in;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= c_seed;
      end else if (ena) begin
         r_lfsr <= w_next;
      end
   end

   assign masked = r_lfsr[GAP_W-1:0] & mask;

endmodule
`default_nettype wire

// File: rtl/pulse_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pulse_burst_scheduler
// Brief    : Emits bursts of fixed-width pulses separated by min_gap plus an
//            LFSR-randomised extension. Macro PULSE_SCHED_SEED_LOAD_EN adds
//            seed_load/seed_in ports for reseeding the LFSR.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_burst_scheduler
   import pulse_sched_pkg::*;
#(
   parameter int CNT_W  = 8,
   parameter int GAP_W  = 8,
   parameter int PW_W   = 4,
   parameter int LFSR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  burst_len,
   input  logic [PW_W-1:0]   pulse_width,
   input  logic [GAP_W-1:0]  min_gap,
   input  logic [GAP_W-1:0]  gap_mask,
`ifdef PULSE_SCHED_SEED_LOAD_EN
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
`endif
   output logic              pulse,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  pulses_left
);

   // one down-counter serves both the pulse width and the (GAP_W+1)-bit gap
   localparam int c_tmr_w = (GAP_W + 1 > PW_W) ? GAP_W + 1 : PW_W;

   state_e             r_state;
   logic               r_pulse;
   logic [CNT_W-1:0]   r_left;
   logic [c_tmr_w-1:0] r_tmr;
   logic [PW_W-1:0]    r_pw;
   logic [GAP_W-1:0]   r_min_gap;
   logic [GAP_W-1:0]   r_mask;

   logic [GAP_W-1:0]   w_masked;
   logic [GAP_W:0]     w_gap;
   logic [GAP_W:0]     w_gap_m1;
   logic [PW_W-1:0]    w_pw_new_m1;
   logic [PW_W-1:0]    w_pw_cur_m1;

   pulse_lfsr #(
      .LFSR_W (LFSR_W),
      .GAP_W  (GAP_W)
   ) u_lfsr (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
`ifdef PULSE_SCHED_SEED_LOAD_EN
      .seed_load (seed_load),
      .seed_in   (seed_in),
`endif
      .mask      (r_mask),
      .masked    (w_masked)
   );

   // timer reload values are the effective length minus one
   assign w_gap       = {1'b0, r_min_gap} + {1'b0, w_masked};
   assign w_gap_m1    = (w_gap == '0) ? '0 : w_gap - 1'b1;
   assign w_pw_new_m1 = (pulse_width == '0) ? '0 : pulse_width - 1'b1;
   assign w_pw_cur_m1 = (r_pw == '0) ? '0 : r_pw - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pulse   <= 1'b0;
         r_left    <= '0;
         r_tmr     <= '0;
         r_pw      <= '0;
         r_min_gap <= '0;
         r_mask    <= '0;
      end else if (ena) begin
         if (abort && (r_state != IDLE)) begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
            r_left  <= '0;
            r_tmr   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start && !abort) begin
                     r_pw      <= pulse_width;
                     r_min_gap <= min_gap;
                     r_mask    <= gap_mask;
                     if (burst_len == '0) begin
                        r_state <= DONE;
                     end else begin
                        r_state <= HIGH;
                        r_pulse <= 1'b1;
                        r_left  <= burst_len - 1'b1;
                        r_tmr   <= c_tmr_w'(w_pw_new_m1);
                     end
                  end
               end
               HIGH: begin
                  if (r_tmr == '0) begin
                     r_pulse <= 1'b0;
                     if (r_left == '0) begin
                        r_state <= DONE;
                     end else begin
                        r_state <= GAP;
                        r_tmr   <= c_tmr_w'(w_gap_m1);
                     end
                  end else begin
                     r_tmr <= r_tmr - 1'b1;
                  end
               end
               GAP: begin
                  if (r_tmr == '0) begin
                     r_state <= HIGH;
                     r_pulse <= 1'b1;
                     r_left  <= r_left - 1'b1;
                     r_tmr   <= c_tmr_w'(w_pw_cur_m1);
                  end else begin
                     r_tmr <= r_tmr - 1'b1;
                  end
               end
               DONE: begin
                  r_state <= IDLE;
               end
               default: begin
                  r_state <= IDLE;
               end
            endcase
         end
      end
   end

   assign pulse       = r_pulse;
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);
   assign pulses_left = r_left;

endmodule
`default_nettype wire

// File: tb/tb_pulse_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_burst_scheduler
// Brief    : Self-checking bench for pulse_burst_scheduler against a
//            burst-level schedule model. Honours PULSE_SCHED_SEED_LOAD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_burst_scheduler;

   localparam int CNT_W  = 8;
   localparam int GAP_W  = 8;
   localparam int PW_W   = 4;
   localparam int LFSR_W = 16;

   logic             clk         = 1'b0;
   logic             rst_n       = 1'b0;
   logic             ena         = 1'b0;
   logic             start       = 1'b0;
   logic             abort       = 1'b0;
   logic [CNT_W-1:0] burst_len   = '0;
   logic [PW_W-1:0]  pulse_width = '0;
   logic [GAP_W-1:0] min_gap     = '0;
   logic [GAP_W-1:0] gap_mask    = '0;
`ifdef PULSE_SCHED_SEED_LOAD_EN
   logic              seed_load  = 1'b0;
   logic [LFSR_W-1:0] seed_in    = '0;
`endif
   logic             pulse;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] pulses_left;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] m_lfsr;
   bit          exp_p[$];
   bit          exp_b[$];
   bit          exp_d[$];
   int          exp_l[$];
   int          exp_gaps[$];
   int          obs_gaps[$];

   pulse_burst_scheduler #(
      .CNT_W  (CNT_W),
      .GAP_W  (GAP_W),
      .PW_W   (PW_W),
      .LFSR_W (LFSR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .start       (start),
      .abort       (abort),
      .burst_len   (burst_len),
      .pulse_width (pulse_width),
      .min_gap     (min_gap),
      .gap_mask    (gap_mask),
`ifdef PULSE_SCHED_SEED_LOAD_EN
      .seed_load   (seed_load),
      .seed_in     (seed_in),
`endif
      .pulse       (pulse),
      .busy        (busy),
      .done        (done),
      .pulses_left (pulses_left)
   );

   always #5 clk = ~clk;

   // x^16+x^14+x^13+x^11+1 -> bits 15,13,12,10 in the right-shift Galois form
   function automatic logic [15:0] m_step(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_lfsr <= 16'hACE1;
      end else if (ena) begin
`ifdef PULSE_SCHED_SEED_LOAD_EN
         if (seed_load) m_lfsr <= (seed_in == 16'h0) ? 16'hACE1 : seed_in;
         else           m_lfsr <= m_step(m_lfsr);
`else
         m_lfsr <= m_step(m_lfsr);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected per-cycle outputs for cycles 1.. after the accepting edge, from the burst rules.
   task automatic build_expect(input int len, input int pw, input int mg, input int mask,
                               input logic [15:0] l0);
      logic [15:0] cur;
      int          epw;
      int          g;
      exp_p.delete(); exp_b.delete(); exp_d.delete(); exp_l.delete(); exp_gaps.delete();
      cur = l0;
      epw = (pw == 0) ? 1 : pw;
      for (int p = 0; p < len; p++) begin
         for (int w = 0; w < epw; w++) begin
            cur = m_step(cur);
            exp_p.push_back(1'b1); exp_b.push_back(1'b1); exp_d.push_back(1'b0);
            exp_l.push_back(len - 1 - p);
         end
         if (p < len - 1) begin
            g = mg + (int'(cur[7:0]) & mask);
            if (g == 0) g = 1;
            exp_gaps.push_back(g);
            for (int w = 0; w < g; w++) begin
               cur = m_step(cur);
               exp_p.push_back(1'b0); exp_b.push_back(1'b1); exp_d.push_back(1'b0);
               exp_l.push_back(len - 1 - p);
            end
         end
      end
      exp_p.push_back(1'b0); exp_b.push_back(1'b1); exp_d.push_back(1'b1); exp_l.push_back(0);
      exp_p.push_back(1'b0); exp_b.push_back(1'b0); exp_d.push_back(1'b0); exp_l.push_back(0);
   endtask

   task automatic run_burst(input string name, input int len, input int pw, input int mg,
                            input int mask, input int abort_at, input int poke_at,
                            input int freeze_at);
      logic [CNT_W+2:0] want;
      int               run_low;
      burst_len   = CNT_W'(len);
      pulse_width = PW_W'(pw);
      min_gap     = GAP_W'(mg);
      gap_mask    = GAP_W'(mask);
      start       = 1'b1;
      build_expect(len, pw, mg, mask, m_lfsr);
      tick();
      start       = 1'b0;
      burst_len   = CNT_W'($urandom);
      pulse_width = PW_W'($urandom);
      min_gap     = GAP_W'($urandom);
      gap_mask    = GAP_W'($urandom);
      obs_gaps.delete();
      run_low = 0;
      for (int k = 0; k < exp_p.size(); k++) begin
         want = {exp_p[k], exp_b[k], exp_d[k], CNT_W'(exp_l[k])};
         n_tests++;
         if ({pulse, busy, done, pulses_left} !== want) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got pulse/busy/done/left=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                     name, k + 1, pulse, busy, done, pulses_left,
                     exp_p[k], exp_b[k], exp_d[k], exp_l[k]);
         end
         if (busy && !pulse && !done) begin
            run_low++;
         end else if (pulse && run_low > 0) begin
            obs_gaps.push_back(run_low);
            run_low = 0;
         end
         if (k + 1 == abort_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            n_tests++;
            if ({pulse, busy, done, pulses_left} !== '0) begin
               n_fail++;
               $display("FAIL %s abort_idle: got pulse/busy/done/left=%b/%b/%b/%0d expected 0/0/0/0",
                        name, pulse, busy, done, pulses_left);
            end
            for (int i = 0; i < 3; i++) begin
               tick();
               n_tests++;
               if (done !== 1'b0 || busy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL %s abort_no_done: got busy=%b done=%b expected 0/0", name, busy, done);
               end
            end
            return;
         end
         if (k + 1 == freeze_at) begin
            ena = 1'b0;
            for (int f = 0; f < 10; f++) begin
               tick();
               n_tests++;
               if ({pulse, busy, done, pulses_left} !== want) begin
                  n_fail++;
                  $display("FAIL %s freeze_hold %0d: got pulse/busy/done/left=%b/%b/%b/%0d expected %b/%b/%b/%0d",
                           name, f, pulse, busy, done, pulses_left,
                           exp_p[k], exp_b[k], exp_d[k], exp_l[k]);
               end
            end
            ena = 1'b1;
         end
         if (k + 1 == poke_at) begin
            start       = 1'b1;
            burst_len   = 8'd9;
            pulse_width = 4'd7;
         end
         tick();
         start = 1'b0;
      end
   endtask

   task automatic test_reset();
      n_tests++;
      if ({pulse, busy, done, pulses_left} !== '0 || dut.u_lfsr.r_lfsr !== 16'hACE1) begin
         n_fail++;
         $display("FAIL reset_state: got pulse/busy/done/left=%b/%b/%b/%0d lfsr=%h expected 0/0/0/0 lfsr=ace1",
                  pulse, busy, done, pulses_left, dut.u_lfsr.r_lfsr);
      end
   endtask

   task automatic test_deterministic();
      run_burst("det", 3, 2, 4, 0, 0, 0, 0);
      n_tests++;
      if (obs_gaps.size() != 2 || obs_gaps[0] != 4 || obs_gaps[1] != 4) begin
         n_fail++;
         $display("FAIL det_gaps: got %0d gaps (first=%0d) expected 2 gaps of 4",
                  obs_gaps.size(), (obs_gaps.size() > 0) ? obs_gaps[0] : -1);
      end
   endtask

   task automatic test_zero_edge();
      run_burst("len0", 0, 3, 5, 8'h3C, 0, 0, 0);
      run_burst("pw0_gap0", 2, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_random_gaps();
      run_burst("rand_gap", 5, 1 + int'($urandom_range(0, 2)), 2, 8'h0F, 0, 0, 0);
      n_tests++;
      if (obs_gaps.size() != 4) begin
         n_fail++;
         $display("FAIL rand_gap_count: got %0d expected 4", obs_gaps.size());
      end
      foreach (obs_gaps[i]) begin
         n_tests++;
         if (obs_gaps[i] < 2 || obs_gaps[i] > 17) begin
            n_fail++;
            $display("FAIL rand_gap_range: gap %0d got %0d expected 2..17", i, obs_gaps[i]);
         end
      end
      for (int r = 0; r < 4; r++) begin
         run_burst("rand_cfg", int'($urandom_range(0, 6)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 255)), 0, 0, 0);
      end
   endtask

   task automatic test_abort();
      run_burst("abort_gap2", 4, 1, 3, 0, 7, 0, 0);
      start = 1'b1;
      abort = 1'b1;
      burst_len = 8'd2;
      tick();
      start = 1'b0;
      abort = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_beats_start: got busy=%b pulse=%b expected 0/0", busy, pulse);
      end
   endtask

   task automatic test_back_to_back();
      run_burst("busy_start", 3, 2, 3, 1, 0, 4, 0);
      run_burst("b2b_second", 2, 3, 1, 2, 0, 0, 0);
   endtask

   task automatic test_enable();
      run_burst("freeze", 3, 4, 3, 8'h07, 0, 0, 2);
   endtask

   task automatic test_reset_mid_burst();
      burst_len   = 8'd3;
      pulse_width = 4'd5;
      min_gap     = 8'd2;
      gap_mask    = 8'd0;
      start       = 1'b1;
      tick();
      start       = 1'b0;
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({pulse, busy, done, pulses_left} !== '0 || dut.u_lfsr.r_lfsr !== 16'hACE1) begin
         n_fail++;
         $display("FAIL reset_mid_burst: got pulse/busy/done/left=%b/%b/%b/%0d lfsr=%h expected 0/0/0/0 lfsr=ace1",
                  pulse, busy, done, pulses_left, dut.u_lfsr.r_lfsr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      n_tests++;
      if (busy !== 1'b0 || pulse !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_idle: got busy=%b pulse=%b expected 0/0", busy, pulse);
      end
   endtask

`ifdef PULSE_SCHED_SEED_LOAD_EN
   task automatic test_seed_load();
      seed_in   = 16'h1234;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      n_tests++;
      if (dut.u_lfsr.r_lfsr !== 16'h1234) begin
         n_fail++;
         $display("FAIL seed_1234: got %h expected 1234", dut.u_lfsr.r_lfsr);
      end
      run_burst("seed_1234", 4, 1, 1, 8'hFF, 0, 0, 0);
      seed_in   = 16'h0000;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      n_tests++;
      if (dut.u_lfsr.r_lfsr !== 16'hACE1) begin
         n_fail++;
         $display("FAIL seed_zero: got %h expected ace1", dut.u_lfsr.r_lfsr);
      end
      run_burst("seed_zero", 3, 2, 0, 8'hFF, 0, 0, 0);
   endtask
`endif

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      tick();
      test_deterministic();
      test_zero_edge();
      test_random_gaps();
      test_abort();
      test_back_to_back();
      test_enable();
      test_reset_mid_burst();
`ifdef PULSE_SCHED_SEED_LOAD_EN
      test_seed_load();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/pulse_burst_scheduler.md
Name: pulse_burst_scheduler

Overview:
Sequences bursts of randomly spaced pulses for the random pulse output path. On a start request it emits a programmed number of fixed-width pulses. Pulses are separated by gaps of minimum length plus an LFSR-derived random extension. A done strobe marks burst completion. It sits between the top-level wrapper's control inputs and the pulse output bit on uio_out[0].

Parameters:
CNT_W, 8, width of burst length and remaining-pulse counter
GAP_W, 8, width of min_gap and gap_mask
PW_W, 4, width of pulse_width
LFSR_W, 16, LFSR width (fixed taps for 16 only)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
start  in  1  burst request, sampled in IDLE only
abort  in  1  cancel burst in progress
burst_len  in  CNT_W  pulses per burst, latched on start
pulse_width  in  PW_W  high cycles per pulse, latched on start
min_gap  in  GAP_W  minimum low cycles between pulses, latched on start
gap_mask  in  GAP_W  mask applied to LFSR for random gap extension, latched on start
pulse  out  1  pulse output
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion strobe
pulses_left  out  CNT_W  pulses not yet started in current burst

Behaviour:
- Reset (async, rst_n low): state IDLE; pulse=0, busy=0, done=0, pulses_left=0; LFSR=16'hACE1; all counters 0.
- ena low: FSM, counters, LFSR and all outputs hold their values; start/abort ignored.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle ena=1. Never reaches all-zeros.
- FSM states are IDLE, HIGH, GAP and DONE.
- IDLE: start=1 and abort=0 latches config. If burst_len=0, go to DONE (no pulse). Otherwise go to HIGH with pulses_left=burst_len-1.
- Latency: start sampled at edge N means pulse=1 and busy=1 from cycle N+1.
- HIGH: pulse=1 for eff_pw = max(pulse_width,1) cycles.
  - At the end, if pulses_left=0, go to DONE (no trailing gap).
  - Otherwise go to GAP.
- GAP entry: gap = min_gap + (lfsr[GAP_W-1:0] & gap_mask), computed in GAP_W+1 bits with no overflow. eff_gap = max(gap,1). LFSR value sampled on the cycle HIGH ends.
- GAP: pulse=0 for eff_gap cycles, then go to HIGH with pulses_left decremented.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- start while busy is ignored; no queuing.
- abort=1 in HIGH/GAP/DONE: next cycle IDLE, pulse=0, pulses_left=0, no done strobe. abort beats start in IDLE.
- Config inputs are don't-care except on the accepting start edge.
- pulse is registered, so it is glitch-free.

Optional Feature:
Macro PULSE_SCHED_SEED_LOAD_EN.
- Defined: adds ports seed_load (in, 1) and seed_in (in, LFSR_W).
  - seed_load=1 with ena=1 loads LFSR=seed_in next cycle, overriding the advance.
  - seed_in=0 loads 16'hACE1 instead.
- Undefined: ports absent; LFSR only reset-seeded.

Decomposition:
- Package pulse_sched_pkg holds:
  - state enum (IDLE, HIGH, GAP, DONE)
  - LFSR_SEED = 16'hACE1
  - LFSR_TAPS = 16'hB400
- Sub-module pulse_lfsr contains the LFSR register, enable, optional seed load and a masked-value output. The FSM/counter logic stays in pulse_burst_scheduler.

Test Plan:
- Reset mid-burst: assert rst_n low during HIGH -> pulse/busy/done/pulses_left immediately 0; LFSR=16'hACE1.
- Deterministic burst: burst_len=3, pulse_width=2, min_gap=4, gap_mask=0, start at edge 0 ->
  - pulse high in cycles 1-2, 7-8 and 13-14, low otherwise;
  - done only in cycle 15; busy high in cycles 1-15.
- Zero/edge values:
  - burst_len=0 -> no pulse; done in cycle 1.
  - pulse_width=0, min_gap=0, gap_mask=0, burst_len=2 -> pulse high in cycles 1 and 3, low in cycle 2.
- Random gaps: burst_len=5, min_gap=2, gap_mask=8'h0F -> every gap in [2,17] and matches a reference LFSR model cycle-for-cycle.
- Abort and enable:
  - abort during the second GAP -> IDLE next cycle, no done.
  - start during busy -> ignored.
  - ena low for 10 cycles mid-HIGH -> pulse held; the burst resumes with identical remaining timing.
- With PULSE_SCHED_SEED_LOAD_EN: seed_in=16'h1234 loaded, then gap_mask=8'hFF -> gaps match model seeded with 16'h1234. seed_in=0 -> behaves as seed 16'hACE1.
